// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache controllers: fill FSM states and way-index sizing.
// Pure declarations; no logic, latency or flow control of its own.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    FILL     = 2'd2
  } fill_state_e;

  // A single-way cache still carries a 1-bit way index so ports never collapse to zero width.
  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/component_register.sv
// Generic enabled register with asynchronous active-low clear.
// One-cycle latency from d to q when en is high; no backpressure.
module component_register #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cache_we_ctrl.sv
// Cache array write strobe / way select for CPU write hits, write-allocate misses and memory refills.
// Write strobes are combinational (0 cycles); a read miss stalls the CPU until the one-cycle FILL completes.
module cache_we_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int  WAYS           = 2,
  parameter int  WRITE_ALLOCATE = 0,
  parameter int  CNT_W          = 16,
  localparam int WAY_W          = way_width(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic             hit,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             mem_ready,
  output logic             cache_we,
  output logic [WAY_W-1:0] we_way,
  output logic             fill_sel,
  output logic             mem_req,
  output logic             stall,
  output logic [CNT_W-1:0] miss_count
);

  fill_state_e      state;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] victim_nxt;
  logic             in_idle;
  logic             wr_miss;
  logic             rd_miss;
  logic             alloc;
  logic             advance;

  assign in_idle = (state == IDLE);
  assign wr_miss = in_idle & we & ~hit;
  // A simultaneous write takes priority; the CPU re-presents the read later.
  assign rd_miss = in_idle & re & ~we & ~hit;
  assign alloc   = wr_miss & (WRITE_ALLOCATE != 0);
  assign advance = alloc | (state == FILL);

  assign victim_nxt = (WAYS == 1) ? '0 : victim + WAY_W'(1);

  component_register #(
    .WIDTH (WAY_W)
  ) u_victim (
    .clk (clk),
    .rst (rst),
    .en  (advance),
    .d   (victim_nxt),
    .q   (victim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      miss_count <= '0;
    end else begin
      if ((wr_miss || rd_miss) && (miss_count != {CNT_W{1'b1}})) begin
        miss_count <= miss_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (rd_miss) begin
            state   <= WAIT_MEM;
            mem_req <= 1'b1;
          end
        end
        WAIT_MEM: begin
          if (mem_ready) begin
            state   <= FILL;
            mem_req <= 1'b0;
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are gated by reset so an aborted fill can never produce a partial write.
  always_comb begin
    cache_we = 1'b0;
    we_way   = '0;
    fill_sel = 1'b0;
    stall    = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          stall = rd_miss;
          if (we && hit) begin
            cache_we = 1'b1;
            we_way   = hit_way;
          end else if (alloc) begin
            cache_we = 1'b1;
            we_way   = victim;
          end
        end
        WAIT_MEM: begin
          stall = 1'b1;
        end
        FILL: begin
          cache_we = 1'b1;
          we_way   = victim;
          fill_sel = 1'b1;
          stall    = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_we_ctrl.sv
// Bench for cache_we_ctrl: three configurations share one stimulus stream, checked every cycle
// against a transaction-level model plus directed literal expectations.
module tb_cache_we_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0, re = 1'b0, hit = 1'b0, mem_ready = 1'b0;
  logic [1:0]  hit_way = 2'd0;

  logic        a_cache_we, a_fill_sel, a_mem_req, a_stall;
  logic [1:0]  a_we_way;
  logic [15:0] a_miss_count;
  logic        b_cache_we, b_fill_sel, b_mem_req, b_stall;
  logic [1:0]  b_we_way;
  logic [1:0]  b_miss_count;
  logic        c_cache_we, c_fill_sel, c_mem_req, c_stall;
  logic [0:0]  c_we_way;
  logic [15:0] c_miss_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_we_ctrl #(.WAYS(4), .WRITE_ALLOCATE(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .we(we), .re(re), .hit(hit), .hit_way(hit_way), .mem_ready(mem_ready),
    .cache_we(a_cache_we), .we_way(a_we_way), .fill_sel(a_fill_sel), .mem_req(a_mem_req),
    .stall(a_stall), .miss_count(a_miss_count));

  cache_we_ctrl #(.WAYS(4), .WRITE_ALLOCATE(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .we(we), .re(re), .hit(hit), .hit_way(hit_way), .mem_ready(mem_ready),
    .cache_we(b_cache_we), .we_way(b_we_way), .fill_sel(b_fill_sel), .mem_req(b_mem_req),
    .stall(b_stall), .miss_count(b_miss_count));

  cache_we_ctrl #(.WAYS(1), .WRITE_ALLOCATE(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .we(we), .re(re), .hit(hit), .hit_way(1'b0), .mem_ready(mem_ready),
    .cache_we(c_cache_we), .we_way(c_we_way), .fill_sel(c_fill_sel), .mem_req(c_mem_req),
    .stall(c_stall), .miss_count(c_miss_count));

  // Model: per configuration, whether a read miss is outstanding and whether memory has answered it.
  int ways   [3] = '{4, 4, 1};
  int wa     [3] = '{0, 1, 1};
  int cntmax [3] = '{65535, 3, 65535};
  bit busy     [3];
  bit answered [3];
  int victim   [3];
  int misses   [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        busy[i] = 0; answered[i] = 0; victim[i] = 0; misses[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!busy[i]) begin
          if (we && !hit) begin
            misses[i]++;
            if (wa[i] != 0) victim[i] = (victim[i] + 1) % ways[i];
          end else if (re && !hit) begin
            misses[i]++;
            busy[i] = 1;
          end
        end else if (!answered[i]) begin
          if (mem_ready) answered[i] = 1;
        end else begin
          victim[i] = (victim[i] + 1) % ways[i];
          busy[i] = 0;
          answered[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] c_we, input logic [31:0] way,
                          input logic [31:0] fs, input logic [31:0] mr, input logic [31:0] st,
                          input logic [31:0] cnt);
    int e_we, e_way, e_fs, e_mr, e_st, e_cnt;
    e_we = 0; e_way = 0; e_fs = 0; e_mr = 0; e_st = 0; e_cnt = 0;
    if (rst) begin
      e_cnt = (misses[i] > cntmax[i]) ? cntmax[i] : misses[i];
      if (!busy[i]) begin
        if (we && hit) begin
          e_we = 1; e_way = int'(hit_way) % ways[i];
        end else if (we && wa[i] != 0) begin
          e_we = 1; e_way = victim[i];
        end else if (!we && re && !hit) begin
          e_st = 1;
        end
      end else if (!answered[i]) begin
        e_mr = 1; e_st = 1;
      end else begin
        e_we = 1; e_way = victim[i]; e_fs = 1; e_st = 1;
      end
    end
    chk($sformatf("model cfg%0d cache_we", i), c_we, e_we);
    chk($sformatf("model cfg%0d we_way", i), way, e_way);
    chk($sformatf("model cfg%0d fill_sel", i), fs, e_fs);
    chk($sformatf("model cfg%0d mem_req", i), mr, e_mr);
    chk($sformatf("model cfg%0d stall", i), st, e_st);
    chk($sformatf("model cfg%0d miss_count", i), cnt, e_cnt);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, a_cache_we, a_we_way, a_fill_sel, a_mem_req, a_stall, a_miss_count);
    cmp_inst(1, b_cache_we, b_we_way, b_fill_sel, b_mem_req, b_stall, b_miss_count);
    cmp_inst(2, c_cache_we, c_we_way, c_fill_sel, c_mem_req, c_stall, c_miss_count);
  end

  task automatic cyc(input bit w, input bit r, input bit h, input logic [1:0] hw, input bit mr);
    @(posedge clk);
    #1;
    we = w; re = r; hit = h; hit_way = hw; mem_ready = mr;
    @(negedge clk);
  endtask

  // Read miss answered k cycles after it is taken; the CPU holds re throughout and re-presents as a hit.
  task automatic read_miss(input int k, input int exp_way);
    cyc(0, 1, 0, 2'd0, 0);
    chk("rm stall at T", a_stall, 1);
    chk("rm mem_req at T", a_mem_req, 0);
    for (int j = 1; j <= k; j++) begin
      cyc(0, 1, 0, 2'd0, (j == k));
      chk("rm mem_req waiting", a_mem_req, 1);
      chk("rm no strobe waiting", a_cache_we, 0);
    end
    cyc(0, 1, 0, 2'd0, 0);
    chk("fill cache_we", a_cache_we, 1);
    chk("fill fill_sel", a_fill_sel, 1);
    chk("fill stall", a_stall, 1);
    chk("fill mem_req", a_mem_req, 0);
    chk("fill way cfg0", a_we_way, exp_way);
    chk("fill way cfg1", b_we_way, exp_way);
    chk("fill way cfg2", c_we_way, 0);
    cyc(0, 1, 1, 2'd0, 0);
    chk("after fill stall", a_stall, 0);
    chk("after fill cache_we", a_cache_we, 0);
    cyc(0, 0, 0, 2'd0, 0);
  endtask

  int fill_ways [4] = '{1, 2, 3, 0};

  initial begin
    repeat (2) @(negedge clk);
    chk("reset miss_count", a_miss_count, 0);
    chk("reset mem_req", a_mem_req, 0);
    chk("reset cache_we", a_cache_we, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("idle no request stall", a_stall, 0);

    cyc(1, 0, 1, 2'd2, 0);
    chk("write hit cache_we", a_cache_we, 1);
    chk("write hit we_way", a_we_way, 2);
    chk("write hit fill_sel", a_fill_sel, 0);
    chk("write hit miss_count", a_miss_count, 0);

    read_miss(3, 0);
    chk("one read miss count", a_miss_count, 1);
    for (int i = 0; i < 4; i++) read_miss(1, fill_ways[i]);
    chk("five misses cfg0", a_miss_count, 5);
    chk("five misses saturate cfg1", b_miss_count, 3);
    chk("five misses cfg2", c_miss_count, 5);

    cyc(1, 0, 0, 2'd0, 0);
    chk("no-alloc write miss strobe", a_cache_we, 0);
    chk("alloc write miss strobe", b_cache_we, 1);
    chk("alloc write miss way", b_we_way, 1);
    chk("single way alloc way", c_we_way, 0);
    cyc(1, 0, 0, 2'd0, 0);
    chk("alloc victim advanced", b_we_way, 2);
    chk("write miss counted", a_miss_count, 6);
    cyc(1, 1, 0, 2'd0, 0);
    chk("write wins no stall", a_stall, 0);
    chk("write wins alloc way", b_we_way, 3);
    cyc(0, 0, 0, 2'd0, 0);
    chk("write wins no mem_req", a_mem_req, 0);
    chk("write wins count", a_miss_count, 8);

    cyc(0, 1, 0, 2'd0, 0);
    cyc(0, 1, 0, 2'd0, 0);
    chk("pre-abort mem_req", a_mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort mem_req", a_mem_req, 0);
    chk("abort miss_count", a_miss_count, 0);
    chk("abort stall", a_stall, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; we = 0; re = 0; hit = 0; mem_ready = 1;
    @(negedge clk);
    chk("post-abort no strobe", a_cache_we, 0);
    chk("post-abort mem_req", a_mem_req, 0);
    cyc(0, 0, 0, 2'd0, 1);
    chk("post-abort still no strobe", a_cache_we, 0);
    chk("post-abort miss_count", a_miss_count, 0);
    read_miss(2, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got no summary, expected one");
    $fatal(1);
  end

endmodule

// File: doc/cache_we_ctrl.md
# cache_we_ctrl

Parametrised cache write-enable and miss-fill controller for the N-way data cache. It generates the cache array write strobe and way select for CPU write hits, optional write-allocate misses, and memory refills after read misses. It replaces the fixed one-cycle miss-refill strobe with a handshaked fill FSM, a round-robin victim pointer and a miss counter. It sits between the CPU request decode and the tag/data arrays, alongside the hit-compare logic.

## Interface
Parameters:
- WAYS, 2, number of cache ways (power of two, ≥1)
- WRITE_ALLOCATE, 0, 1 = write misses allocate into the victim way; 0 = write-no-allocate
- CNT_W, 16, width of the saturating miss counter
- Derived: WAY_W = max(1, $clog2(WAYS))

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  1  CPU write request
- re  in  1  CPU read request
- hit  in  1  tag compare hit for the current request
- hit_way  in  WAY_W  way that hit; valid only when hit=1
- mem_ready  in  1  memory refill data valid
- cache_we  out  1  data/tag array write strobe
- we_way  out  WAY_W  way written when cache_we=1
- fill_sel  out  1  1 = write data from memory; 0 = from CPU
- mem_req  out  1  refill request to memory
- stall  out  1  CPU must hold its request
- miss_count  out  CNT_W  read plus write misses since reset, saturating

## Operation
- States are IDLE, WAIT_MEM and FILL. Reset state is IDLE.
- Registered reset values: victim=0, miss_count=0, mem_req=0. All combinational outputs are 0 in IDLE with no request.
- **IDLE, we=1, hit=1:** cache_we=1 the same cycle (combinational), we_way=hit_way, fill_sel=0.
- **IDLE, we=1, hit=0:**
  - WRITE_ALLOCATE=1: cache_we=1, we_way=victim, fill_sel=0, and victim advances.
  - WRITE_ALLOCATE=0: cache_we=0.
  - In both modes miss_count increments.
- **IDLE, re=1, we=0, hit=0:** stall=1 combinationally, miss_count increments, and the next state is WAIT_MEM.
- **IDLE, re=1, hit=1:** no action.
- **we=1 and re=1 together:** the write wins. The read is not serviced that cycle; the CPU re-presents it.
- **WAIT_MEM:** mem_req=1 and stall=1. If mem_ready=1, the next state is FILL; otherwise stay in WAIT_MEM. we/re are ignored.
- **FILL (exactly one cycle):** cache_we=1, we_way=victim, fill_sel=1, stall=1, mem_req=0. Then victim advances and the next state is IDLE.
- **Victim pointer:** victim = (victim+1) mod WAYS, wrapping from WAYS-1 to 0. With WAYS=1 it stays 0.
- **miss_count:** saturates at 2^CNT_W−1 and does not wrap.
- mem_ready outside WAIT_MEM is ignored.
- Reset asserted mid-operation aborts any fill immediately (asynchronously): state goes to IDLE, mem_req=0, cache_we=0, and counters clear. No partial refill write occurs.

## Timing
- Write-hit and write-allocate strobes have 0-cycle latency (combinational from we/hit in IDLE).
- For a read miss at cycle T:
  - mem_req is high from T+1.
  - If mem_ready is first sampled high at cycle T+k (k≥1), then cache_we=1 with fill_sel=1 at T+k+1.
  - stall is high T..T+k+1, and the block is back in IDLE at T+k+2.
- Minimum miss penalty is 3 cycles of stall (mem_ready already high at T+1).
- mem_req is level, held until mem_ready is sampled high, and drops in FILL.
- cache_we is never high for more than one cycle per fill.

## Structure
- Package cache_ctrl_pkg holds the state enum type (IDLE, WAIT_MEM, FILL). Later cache controllers share it.
- Reuse the existing component_register for the victim pointer (WIDTH=WAY_W, en = advance condition).
- FSM, miss counter and output decode live in cache_we_ctrl itself.

## Test plan
- Reset, then WAYS=4, we=1, hit=1, hit_way=2 → cache_we=1 and we_way=2 in the same cycle; miss_count=0.
- Read miss at T, mem_ready raised at T+3 → mem_req high T+1..T+3, cache_we=1 with fill_sel=1 and we_way=0 at T+4, stall low at T+5, miss_count=1.
- Five consecutive read-miss fills with WAYS=4 → we_way sequence 0,1,2,3,0 (wrap).
- WRITE_ALLOCATE=0 write miss → cache_we=0, miss_count+1. WRITE_ALLOCATE=1 write miss → cache_we=1, we_way=victim, victim+1.
- CNT_W=2, five misses → miss_count stays 3.
- rst pulled low while in WAIT_MEM, then mem_ready=1 after release → no cache_we, state IDLE, mem_req=0, miss_count=0.
